// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit.
// Moore FSM that sequences the shared datapath (ALU, register file, unified
// memory, PC) one step per cycle. Memory-facing states stall on mem_ready,
// and a watchdog traps when memory stops answering.
//
// Handshake: a memory request (MemRead/MemWrite) is held high and steady from
// the first cycle of a FETCH/MEM_READ/MEM_WRITE state until the cycle in which
// mem_ready=1; that cycle completes the transfer and the FSM advances on the
// following edge. mem_ready is ignored in every other state.
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       trap,
    output logic [1:0] trap_cause
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11,
        TRAP      = 4'd12
    } state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    state_t          state_q;
    logic [TO_W-1:0] wd_q;
    logic [1:0]      cause_q;
    logic            wait_state;
    logic            wd_trip;

    // The branch decision (PCWriteCond & zero) is formed in the datapath's PC
    // enable; the flag stays on this port so the interface matches the datapath.
    logic unused_zero;
    assign unused_zero = zero;

    assign state      = state_q;
    assign wait_state = (state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE);
    // Trip only while still waiting: a completion in the limit cycle wins.
    assign wd_trip    = (TIMEOUT_CYCLES != 0) && wait_state && !mem_ready && (wd_q == TO_LIMIT);

    // State sequencing, stall watchdog and sticky trap cause.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FETCH;
            wd_q    <= '0;
            cause_q <= 2'b00;
        end else begin
            if (wait_state && !mem_ready && !wd_trip) begin
                wd_q <= wd_q + 1'b1;
            end else begin
                wd_q <= '0;
            end

            if (wd_trip) begin
                state_q <= TRAP;
                cause_q <= 2'b10;
            end else begin
                case (state_q)
                    FETCH:     if (mem_ready) state_q <= DECODE;
                    DECODE: begin
                        case (opcode)
                            6'h00:        state_q <= R_EXEC;
                            6'h23, 6'h2B: state_q <= MEM_ADDR;
                            6'h04:        state_q <= BRANCH;
                            6'h02:        state_q <= JUMP;
                            6'h08:        state_q <= ADDI_EXEC;
                            default: begin
                                state_q <= TRAP;
                                cause_q <= 2'b01;
                            end
                        endcase
                    end
                    MEM_ADDR:  state_q <= (opcode == 6'h23) ? MEM_READ : MEM_WRITE;
                    MEM_READ:  if (mem_ready) state_q <= MEM_WB;
                    MEM_WB:    state_q <= FETCH;
                    MEM_WRITE: if (mem_ready) state_q <= FETCH;
                    R_EXEC:    state_q <= R_WB;
                    R_WB:      state_q <= FETCH;
                    BRANCH:    state_q <= FETCH;
                    JUMP:      state_q <= FETCH;
                    ADDI_EXEC: state_q <= ADDI_WB;
                    ADDI_WB:   state_q <= FETCH;
                    TRAP:      state_q <= TRAP;
                    default: begin
                        // Codes 13-15 are unreachable encodings; treat as illegal.
                        state_q <= TRAP;
                        cause_q <= 2'b01;
                    end
                endcase
            end
        end
    end

    // Per-state strobes and selects; everything is held at 0 while in reset.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        trap        = 1'b0;
        trap_cause  = 2'b00;
        case (state_q)
            FETCH: begin
                MemRead = !wd_trip;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE:    ALUSrcB = 2'b11;
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEM_READ: begin
                MemRead = !wd_trip;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WRITE: begin
                MemWrite = !wd_trip;
                IorD     = 1'b1;
            end
            R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDI_WB:   RegWrite = 1'b1;
            TRAP:      trap = 1'b1;
            default:   ;
        endcase
        trap_cause = cause_q;
        if (!rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
            trap        = 1'b0;
            trap_cause  = 2'b00;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Each instruction is expanded from its opcode
// into the list of cycles it must take (state, mem_ready driven, expected
// outputs); the driver replays that list and compares the DUT every cycle.
module tb_multicycle_control;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource, trap_cause;
    logic [3:0] state;
    logic       trap;

    int n_cmp = 0;
    int n_err = 0;

    // step = {state[23:20], mem_ready[19], outputs[18:3], trap[2], cause[1:0]}
    logic [23:0] exp_q[$];

    multicycle_control #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .trap(trap), .trap_cause(trap_cause)
    );

    // clock and runaway guard
    always #5 clk = ~clk;
    initial begin
        #400000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1);
    end

    wire [15:0] dut_out = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    // Expected outputs of one state, from the state/output table.
    function automatic logic [15:0] ref_out(int st, bit mr, bit trip);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        logic m2r = 0, rdst = 0, rw = 0, srca = 0;
        logic [1:0] srcb = 0, aluop = 0, pcsrc = 0;
        case (st)
            0: begin mrd = !trip; srcb = 2'b01; irw = mr; pcw = mr; end
            1: srcb = 2'b11;
            2: begin srca = 1; srcb = 2'b10; end
            3: begin mrd = !trip; iord = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mwr = !trip; iord = 1; end
            6: begin srca = 1; aluop = 2'b10; end
            7: begin rw = 1; rdst = 1; end
            8: begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
            9: begin pcw = 1; pcsrc = 2'b10; end
            10: begin srca = 1; srcb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc};
    endfunction

    function automatic logic [23:0] mk(int st, bit mr, bit trip, bit trp, logic [1:0] cause);
        logic [3:0] s4 = 4'(st);
        return {s4, mr, ref_out(st, mr, trip), trp, cause};
    endfunction

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // A memory phase: `waits` idle cycles then completion, or a watchdog trip
    // once more than TO consecutive waits are requested.
    task automatic add_mem_phase(input int st, input int waits, output bit tripped);
        tripped = (waits > TO);
        for (int i = 0; i < ((waits > TO) ? TO : waits); i++) exp_q.push_back(mk(st, 0, 0, 0, 2'b00));
        if (tripped) exp_q.push_back(mk(st, 0, 1, 0, 2'b00));
        else         exp_q.push_back(mk(st, 1, 0, 0, 2'b00));
    endtask

    task automatic add_trap(input int n, input logic [1:0] cause);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(12, rbit(), 0, 1, cause));
    endtask

    // Expand one instruction into its expected cycle list.
    task automatic build_instr(input logic [5:0] op, input int fw, input int mw,
                               input int hold, output bit trapped);
        bit t;
        add_mem_phase(0, fw, t);
        trapped = t;
        if (t) begin add_trap(hold, 2'b10); return; end
        exp_q.push_back(mk(1, rbit(), 0, 0, 2'b00));
        case (op)
            6'h23: begin
                exp_q.push_back(mk(2, rbit(), 0, 0, 2'b00));
                add_mem_phase(3, mw, t);
                if (!t) exp_q.push_back(mk(4, rbit(), 0, 0, 2'b00));
            end
            6'h2B: begin
                exp_q.push_back(mk(2, rbit(), 0, 0, 2'b00));
                add_mem_phase(5, mw, t);
            end
            6'h00: begin exp_q.push_back(mk(6, rbit(), 0, 0, 2'b00)); exp_q.push_back(mk(7, rbit(), 0, 0, 2'b00)); end
            6'h04: exp_q.push_back(mk(8, rbit(), 0, 0, 2'b00));
            6'h02: exp_q.push_back(mk(9, rbit(), 0, 0, 2'b00));
            6'h08: begin exp_q.push_back(mk(10, rbit(), 0, 0, 2'b00)); exp_q.push_back(mk(11, rbit(), 0, 0, 2'b00)); end
            default: begin add_trap(hold, 2'b01); trapped = 1; return; end
        endcase
        if (t) begin add_trap(hold, 2'b10); trapped = 1; end
    endtask

    // Driver + scoreboard: replay the queue, checking every cycle at negedge.
    task automatic drive_queue(input logic [5:0] op, input string tag);
        logic [23:0] s;
        int cyc = 0;
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            mem_ready = s[19];
            opcode    = (s[23:20] == 4'd0) ? 6'($urandom) : op;
            zero      = rbit();
            @(negedge clk);
            n_cmp++;
            if (state !== s[23:20]) begin
                n_err++;
                $display("FAIL %s state cyc%0d: got %0d want %0d", tag, cyc, state, s[23:20]);
            end
            n_cmp++;
            if (dut_out !== s[18:3]) begin
                n_err++;
                $display("FAIL %s outputs cyc%0d st%0d: got %h want %h", tag, cyc, s[23:20], dut_out, s[18:3]);
            end
            n_cmp++;
            if ({trap, trap_cause} !== s[2:0]) begin
                n_err++;
                $display("FAIL %s trap cyc%0d: got %b/%b want %b/%b", tag, cyc, trap, trap_cause, s[2], s[1:0]);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // One reset cycle; outputs must be forced to 0 while rst is low.
    task automatic do_reset(input string tag, input int exp_state);
        rst = 1'b0;
        mem_ready = rbit();
        opcode = 6'($urandom);
        @(negedge clk);
        n_cmp++;
        if (dut_out !== 16'h0 || trap !== 1'b0 || trap_cause !== 2'b00) begin
            n_err++;
            $display("FAIL %s reset_gating: got out=%h trap=%b cause=%b want 0", tag, dut_out, trap, trap_cause);
        end
        if (exp_state >= 0) begin
            n_cmp++;
            if (state !== 4'(exp_state)) begin
                n_err++;
                $display("FAIL %s state_at_reset: got %0d want %0d", tag, state, exp_state);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        do_reset("reset", -1);
        rst = 1'b0;
        do_reset("reset2", 0);
    endtask

    task automatic test_lw();
        bit t;
        build_instr(6'h23, 0, 0, 0, t);
        drive_queue(6'h23, "lw");
    endtask

    task automatic test_r_beq();
        bit t;
        build_instr(6'h00, 0, 0, 0, t);
        drive_queue(6'h00, "rtype");
        build_instr(6'h04, 0, 0, 0, t);
        drive_queue(6'h04, "beq");
    endtask

    task automatic test_sw_stall();
        bit t;
        build_instr(6'h2B, 1, 3, 0, t);
        drive_queue(6'h2B, "sw_stall");
    endtask

    task automatic test_illegal();
        bit t;
        build_instr(6'h3F, 0, 0, 20, t);
        drive_queue(6'h3F, "illegal");
        do_reset("illegal", 12);
        build_instr(6'h02, 0, 0, 0, t);
        drive_queue(6'h02, "after_illegal");
    endtask

    task automatic test_watchdog();
        bit t;
        // limit reached with completion in the same cycle: completion wins
        build_instr(6'h23, TO, TO, 0, t);
        drive_queue(6'h23, "wd_boundary");
        build_instr(6'h08, 6, 0, 3, t);
        drive_queue(6'h08, "wd_fetch");
        do_reset("wd_fetch", 12);
        build_instr(6'h2B, 0, TO + 1, 3, t);
        drive_queue(6'h2B, "wd_memwrite");
        do_reset("wd_memwrite", 12);
    endtask

    task automatic test_reset_mid();
        bit t;
        build_instr(6'h23, 0, 1, 0, t);
        void'(exp_q.pop_back());   // MEM_WB cycle is replaced by a reset cycle
        drive_queue(6'h23, "mid_lw");
        do_reset("mid_lw", 4);
        build_instr(6'h08, 0, 0, 0, t);
        drive_queue(6'h08, "after_mid");
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        bit t;
        logic [5:0] op;
        int fw, mw;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(9, 63)) : ops[$urandom_range(0, 5)];
            fw = ($urandom_range(0, 19) == 0) ? $urandom_range(5, 7) : $urandom_range(0, TO);
            mw = ($urandom_range(0, 19) == 0) ? $urandom_range(5, 7) : $urandom_range(0, TO);
            build_instr(op, fw, mw, $urandom_range(1, 3), t);
            drive_queue(op, "random");
            if (t) do_reset("random", 12);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_r_beq();
        test_sw_stall();
        test_illegal();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
